// File: rtl/spu_slot_scheduler.sv
// SPU frame sequencer: 32 slots x 24 cycles, buffered key-on/key-off delivery
// and one RAM transfer grant per voice slot.
module spu_slot_scheduler (
  input  logic        i_clk,
  input  logic        n_rst,
  input  logic        i_enable,
  input  logic        i_konWrite,
  input  logic [23:0] i_konData,
  input  logic        i_koffWrite,
  input  logic [23:0] i_koffData,
  input  logic        i_xferReq,
  input  logic        i_xferIsRead,
  output logic [4:0]  o_voiceCounter,
  output logic [4:0]  o_currVoice,
  output logic        o_reverbInactive,
  output logic [2:0]  o_reverbSlot,
  output logic        o_sampleTick,
  output logic        o_kon,
  output logic        o_koff,
  output logic        o_isDMAXferRD,
  output logic        o_xferGrant,
  output logic        o_xferAck
);

  typedef enum logic [1:0] {StIdle, StGranted, StWait} xfer_state_e;

  xfer_state_e state_q, state_d;

  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  slot_q, slot_d;
  logic [23:0] kon_pend_q, kon_pend_d;
  logic [23:0] koff_pend_q, koff_pend_d;
  logic        evt_q, evt_d;
  logic        kon_q, kon_d;
  logic        koff_q, koff_d;
  logic        tick_q, tick_d;
  logic        grant_q, grant_d;
  logic        ack_q, ack_d;
  logic        is_rd_q, is_rd_d;

  logic        voice_slot;
  logic        grant_fire;
  logic [23:0] kon_vec, koff_vec, clr_mask;

  assign voice_slot = (slot_q < 5'd24);

  // Slot position and key-event outputs are computed one cycle ahead so that
  // they appear registered exactly at the cycle they describe.
  always_comb begin
    cnt_d  = cnt_q;
    slot_d = slot_q;
    if (!i_enable) begin
      cnt_d  = 5'd0;
      slot_d = 5'd0;
    end else if (cnt_q == 5'd23) begin
      cnt_d  = 5'd0;
      slot_d = slot_q + 5'd1;
    end else begin
      cnt_d = cnt_q + 5'd1;
    end

    tick_d = i_enable && (slot_d == 5'd31) && (cnt_d == 5'd23);
    evt_d  = i_enable && (cnt_d == 5'd0) && (slot_d < 5'd24);

    // A write in the cycle before delivery is bypassed straight to the output.
    kon_vec  = kon_pend_q | (i_konWrite ? i_konData : 24'd0);
    koff_vec = koff_pend_q | (i_koffWrite ? i_koffData : 24'd0);
    kon_d    = evt_d && kon_vec[slot_d];
    koff_d   = evt_d && koff_vec[slot_d] && !kon_vec[slot_d];

    // Clearing happens at the end of the delivery cycle; a write landing in
    // that same cycle wins, so the event is re-delivered next frame.
    clr_mask    = (evt_q && i_enable && voice_slot) ? (24'd1 << slot_q) : 24'd0;
    kon_pend_d  = (kon_pend_q & ~clr_mask) | (i_konWrite ? i_konData : 24'd0);
    koff_pend_d = (koff_pend_q & ~clr_mask) | (i_koffWrite ? i_koffData : 24'd0);
  end

  assign grant_fire = i_enable && (state_q == StIdle) && voice_slot &&
                      (cnt_q == 5'd13) && i_xferReq;

  always_ff @(posedge i_clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (grant_fire) state_d = StGranted;
      StGranted: state_d = StWait;
      StWait:    if (cnt_q == 5'd17) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
    if (!i_enable) state_d = StIdle;
  end

  always_comb begin
    grant_d = grant_fire;
    ack_d   = i_enable && (state_q == StWait) && (cnt_q == 5'd17);
    is_rd_d = grant_fire ? i_xferIsRead : is_rd_q;
  end

  always_ff @(posedge i_clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q       <= 5'd0;
      slot_q      <= 5'd0;
      kon_pend_q  <= 24'd0;
      koff_pend_q <= 24'd0;
      evt_q       <= 1'b0;
      kon_q       <= 1'b0;
      koff_q      <= 1'b0;
      tick_q      <= 1'b0;
      grant_q     <= 1'b0;
      ack_q       <= 1'b0;
      is_rd_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      slot_q      <= slot_d;
      kon_pend_q  <= kon_pend_d;
      koff_pend_q <= koff_pend_d;
      evt_q       <= evt_d;
      kon_q       <= kon_d;
      koff_q      <= koff_d;
      tick_q      <= tick_d;
      grant_q     <= grant_d;
      ack_q       <= ack_d;
      is_rd_q     <= is_rd_d;
    end
  end

  assign o_voiceCounter   = cnt_q;
  assign o_currVoice      = voice_slot ? slot_q : 5'd0;
  assign o_reverbInactive = voice_slot;
  assign o_reverbSlot     = voice_slot ? 3'd0 : slot_q[2:0];
  assign o_sampleTick     = tick_q;
  assign o_kon            = kon_q;
  assign o_koff           = koff_q;
  assign o_isDMAXferRD    = is_rd_q;
  assign o_xferGrant      = grant_q;
  assign o_xferAck        = ack_q;

endmodule

// File: tb/tb_spu_slot_scheduler.sv
// Directed bench for spu_slot_scheduler: frame walk, key events, transfer
// handshake, disable and asynchronous reset.
module tb_spu_slot_scheduler;

  logic        i_clk = 1'b0;
  logic        n_rst;
  logic        i_enable;
  logic        i_konWrite;
  logic [23:0] i_konData;
  logic        i_koffWrite;
  logic [23:0] i_koffData;
  logic        i_xferReq;
  logic        i_xferIsRead;
  logic [4:0]  o_voiceCounter;
  logic [4:0]  o_currVoice;
  logic        o_reverbInactive;
  logic [2:0]  o_reverbSlot;
  logic        o_sampleTick;
  logic        o_kon;
  logic        o_koff;
  logic        o_isDMAXferRD;
  logic        o_xferGrant;
  logic        o_xferAck;

  int fc;
  int checks;
  int failures;
  int n_grant, n_ack, first_grant_fc, first_ack_fc, last_grant_fc;

  spu_slot_scheduler dut (
    .i_clk            (i_clk),
    .n_rst            (n_rst),
    .i_enable         (i_enable),
    .i_konWrite       (i_konWrite),
    .i_konData        (i_konData),
    .i_koffWrite      (i_koffWrite),
    .i_koffData       (i_koffData),
    .i_xferReq        (i_xferReq),
    .i_xferIsRead     (i_xferIsRead),
    .o_voiceCounter   (o_voiceCounter),
    .o_currVoice      (o_currVoice),
    .o_reverbInactive (o_reverbInactive),
    .o_reverbSlot     (o_reverbSlot),
    .o_sampleTick     (o_sampleTick),
    .o_kon            (o_kon),
    .o_koff           (o_koff),
    .o_isDMAXferRD    (o_isDMAXferRD),
    .o_xferGrant      (o_xferGrant),
    .o_xferAck        (o_xferAck)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at fc=%0d: got %0d expected %0d", tag, fc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
    fc++;
    if (o_xferGrant) begin
      if (n_grant == 0) first_grant_fc = fc;
      last_grant_fc = fc;
      n_grant++;
    end
    if (o_xferAck) begin
      if (n_ack == 0) first_ack_fc = fc;
      n_ack++;
    end
  endtask

  task automatic goto(input int t);
    while (fc < t) tick();
  endtask

  task automatic clear_counts();
    n_grant = 0;
    n_ack = 0;
    first_grant_fc = -1;
    first_ack_fc = -1;
    last_grant_fc = -1;
  endtask

  task automatic write_kon(input logic [23:0] d);
    i_konWrite = 1'b1;
    i_konData  = d;
    tick();
    i_konWrite = 1'b0;
    i_konData  = 24'd0;
  endtask

  task automatic write_koff(input logic [23:0] d);
    i_koffWrite = 1'b1;
    i_koffData  = d;
    tick();
    i_koffWrite = 1'b0;
    i_koffData  = 24'd0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    fc = 0;
    clear_counts();
    n_rst = 1'b0;
    i_enable = 1'b1;
    i_konWrite = 1'b0;
    i_konData = 24'd0;
    i_koffWrite = 1'b0;
    i_koffData = 24'd0;
    i_xferReq = 1'b0;
    i_xferIsRead = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_cnt", 32'(o_voiceCounter), 0);
    check("rst_voice", 32'(o_currVoice), 0);
    check("rst_revinact", 32'(o_reverbInactive), 1);
    check("rst_revslot", 32'(o_reverbSlot), 0);
    check("rst_tick", 32'(o_sampleTick), 0);
    check("rst_isrd", 32'(o_isDMAXferRD), 0);
    check("rst_grant", 32'(o_xferGrant), 0);

    // Frame walk and first key-on
    @(negedge i_clk);
    n_rst = 1'b1;
    fc = 0;
    check("f0_cnt0", 32'(o_voiceCounter), 0);
    goto(1);
    check("f0_cnt1", 32'(o_voiceCounter), 1);
    goto(10);
    write_kon(24'h000004);
    goto(47);  check("kon_pre", 32'(o_kon), 0);
    goto(48);  check("kon_v2", 32'(o_kon), 1);
    goto(49);  check("kon_post", 32'(o_kon), 0);
    goto(120); check("v5_start", 32'(o_currVoice), 5);
               check("v5_cnt0", 32'(o_voiceCounter), 0);
    goto(143); check("v5_end", 32'(o_currVoice), 5);
               check("v5_cnt23", 32'(o_voiceCounter), 23);
    goto(144); check("v6_start", 32'(o_currVoice), 6);
    goto(648); check("rv3_slot", 32'(o_reverbSlot), 3);
               check("rv3_inact", 32'(o_reverbInactive), 0);
               check("rv3_voice", 32'(o_currVoice), 0);
    goto(671); check("rv3_end", 32'(o_reverbSlot), 3);
    goto(672); check("rv4_start", 32'(o_reverbSlot), 4);
    goto(766); check("tick_pre", 32'(o_sampleTick), 0);
    goto(767); check("tick_f0", 32'(o_sampleTick), 1);
               check("tick_rv7", 32'(o_reverbSlot), 7);
    goto(768); check("tick_post", 32'(o_sampleTick), 0);
               check("wrap_cnt", 32'(o_voiceCounter), 0);
               check("wrap_inact", 32'(o_reverbInactive), 1);
    goto(816); check("kon_norepeat", 32'(o_kon), 0);
    goto(1535); check("tick_f1", 32'(o_sampleTick), 1);

    // Key-event corner cases
    goto(1540);
    write_kon(24'h000008);
    write_koff(24'h000008);
    write_koff(24'h000200);
    goto(1608); check("v3_kon", 32'(o_kon), 1);
                check("v3_koff", 32'(o_koff), 0);
    goto(1636);
    write_kon(24'h000080);
    goto(1704); check("v7_kon_now", 32'(o_kon), 1);
    write_kon(24'h000080);
    goto(1752); check("v9_koff", 32'(o_koff), 1);
                check("v9_kon", 32'(o_kon), 0);
    goto(2376); check("v3_koff_gone", 32'(o_koff), 0);
                check("v3_kon_gone", 32'(o_kon), 0);
    goto(2472); check("v7_kon_next", 32'(o_kon), 1);
    goto(3240); check("v7_kon_done", 32'(o_kon), 0);
    goto(3335);
    write_kon(24'h000800);
    check("v11_bypass", 32'(o_kon), 1);

    // Transfers held across 30 slots
    goto(3840);
    clear_counts();
    i_xferReq = 1'b1;
    i_xferIsRead = 1'b1;
    goto(4560);
    i_xferReq = 1'b0;
    check("x_grants", 32'(n_grant), 24);
    check("x_acks", 32'(n_ack), 24);
    check("x_first_grant", 32'(first_grant_fc), 3854);
    check("x_first_ack", 32'(first_ack_fc), 3858);
    check("x_last_grant", 32'(last_grant_fc), 4406);
    check("x_isrd1", 32'(o_isDMAXferRD), 1);

    // Late request, drop after grant, drop before grant
    goto(4623);
    clear_counts();
    i_xferReq = 1'b1;
    i_xferIsRead = 1'b0;
    goto(4647);
    i_xferReq = 1'b0;
    goto(4660);
    check("late_grant_fc", 32'(first_grant_fc), 4646);
    check("late_grants", 32'(n_grant), 1);
    check("drop_ack_fc", 32'(first_ack_fc), 4650);
    check("drop_acks", 32'(n_ack), 1);
    check("x_isrd0", 32'(o_isDMAXferRD), 0);
    goto(4685);
    clear_counts();
    i_xferReq = 1'b1;
    goto(4692);
    i_xferReq = 1'b0;
    goto(4704);
    check("early_drop", 32'(n_grant), 0);

    // Disable with a transfer in flight
    goto(5616);
    clear_counts();
    i_xferReq = 1'b1;
    i_xferIsRead = 1'b1;
    goto(5632);
    i_enable = 1'b0;
    tick();
    check("dis_grant_fc", 32'(first_grant_fc), 5630);
    check("dis_cnt", 32'(o_voiceCounter), 0);
    check("dis_voice", 32'(o_currVoice), 0);
    write_kon(24'h000002);
    repeat (10) tick();
    check("dis_noack", 32'(n_ack), 0);
    check("dis_kon", 32'(o_kon), 0);
    check("dis_cnt_held", 32'(o_voiceCounter), 0);
    i_xferReq = 1'b0;
    i_enable = 1'b1;
    fc = 6144;
    goto(6145); check("reen_cnt1", 32'(o_voiceCounter), 1);
    goto(6168); check("reen_voice1", 32'(o_currVoice), 1);
                check("reen_kon1", 32'(o_kon), 1);
                check("reen_noack", 32'(n_ack), 0);

    // Asynchronous reset mid-transfer
    goto(6456);
    clear_counts();
    i_xferReq = 1'b1;
    i_xferIsRead = 1'b1;
    write_kon(24'h100000);
    goto(6470);
    check("rst_pre_grant", 32'(n_grant), 1);
    goto(6472);
    n_rst = 1'b0;
    #1;
    check("arst_cnt", 32'(o_voiceCounter), 0);
    check("arst_voice", 32'(o_currVoice), 0);
    check("arst_inact", 32'(o_reverbInactive), 1);
    check("arst_isrd", 32'(o_isDMAXferRD), 0);
    check("arst_grant", 32'(o_xferGrant), 0);
    i_xferReq = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    n_rst = 1'b1;
    fc = 0;
    clear_counts();
    goto(480);
    check("arst_kon_cleared", 32'(o_kon), 0);
    check("arst_noack", 32'(n_ack), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
